mio_lsu: RTL and testbench

Parametrised load/store unit between the single-cycle RV32I core and the memory/IO bus. It turns the core's one-cycle memory request into a multi-cycle bus transaction and stalls the core until `MIO_ready` is seen. It adds sub-word access (LB/LH/LBU/LHU/SB/SH) with byte enables and data-lane steering. It also reports misaligned-access and bus-timeout errors.

---
 rtl/mio_lsu_pkg.sv | 39 +++
 rtl/mio_lsu_lane.sv | 42 ++++
 rtl/mio_lsu.sv | 137 +++++++++++++
 tb/tb_mio_lsu.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mio_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// funct3 encodings and request legality decode.
package mio_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // True when funct3 is a legal encoding for the direction and the offset
  // satisfies natural alignment for the access size.
  function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    if (we)
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    case (f3[1:0])
      2'b01:   ok = ok & ~off[0];
      2'b10:   ok = ok & (off == 2'b00);
      default: ok = ok;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mio_lsu_lane.sv
// Byte-lane logic: byte enables, store-data replication and load extraction
// with sign/zero extension. Purely combinational.
module mio_lsu_lane
  import mio_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] sdata,
  output logic [31:0] ldata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rword >> {off, 3'b000};
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        sdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {off[1], 1'b0};
        sdata = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        sdata = wdata;
      end
    endcase
    case (funct3)
      F3_LB:   ldata = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   ldata = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  ldata = {24'd0, shifted[7:0]};
      F3_LHU:  ldata = {16'd0, shifted[15:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/mio_lsu.sv
// Load/store unit: turns a single-cycle core memory request into a bus
// transaction, stalling the core until the bus acknowledges or times out.
module mio_lsu
  import mio_lsu_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] Addr_out,
  output logic [31:0] Data_out,
  output logic [3:0]  byte_en,
  output logic        MemRW,
  output logic        CPU_MIO,
  input  logic [31:0] Data_in,
  input  logic        MIO_ready
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT);
  localparam logic            TO_EN   = (TIMEOUT != 0);

  state_t          state;
  logic [TO_W-1:0] cnt;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic            we_q;
  logic [31:0]     ld_word_q;

  logic [1:0]      lane_off;
  logic [2:0]      lane_f3;
  logic [3:0]      lane_be;
  logic [31:0]     lane_sdata;
  logic [31:0]     lane_ldata;
  logic            req_ok;

  // One lane instance serves both paths: the live request while idle
  // (decode), the latched request afterwards (response extraction).
  assign lane_off = (state == ST_IDLE) ? req_addr[1:0]  : off_q;
  assign lane_f3  = (state == ST_IDLE) ? req_funct3     : f3_q;

  mio_lsu_lane u_lane (
    .off    (lane_off),
    .funct3 (lane_f3),
    .wdata  (req_wdata),
    .rword  (ld_word_q),
    .be     (lane_be),
    .sdata  (lane_sdata),
    .ldata  (lane_ldata)
  );

  assign req_ok = req_legal(req_we, req_funct3, req_addr[1:0]);

  // Gated by rst so the core is released the moment reset asserts.
  assign stall     = ~rst & (((state == ST_IDLE) & req_valid) | (state == ST_ACCESS));
  assign rsp_rdata = (rsp_valid & ~rsp_err & ~we_q) ? lane_ldata : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      we_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      Addr_out  <= 32'd0;
      Data_out  <= 32'd0;
      byte_en   <= 4'b0000;
      MemRW     <= 1'b0;
      CPU_MIO   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          if (req_valid) begin
            if (req_ok) begin
              off_q    <= req_addr[1:0];
              f3_q     <= req_funct3;
              we_q     <= req_we;
              cnt      <= '0;
              Addr_out <= {req_addr[31:2], 2'b00};
              Data_out <= lane_sdata;
              byte_en  <= lane_be;
              MemRW    <= req_we;
              CPU_MIO  <= 1'b1;
              state    <= ST_ACCESS;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= ST_ERR;
            end
          end
        end
        ST_ACCESS: begin
          // Ready has priority over an expiring counter.
          if (MIO_ready || (TO_EN && cnt == TO_LAST)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ~MIO_ready;
            state     <= MIO_ready ? ST_DONE : ST_ERR;
            if (!MIO_ready) cnt <= TO_SAT;
            Addr_out  <= 32'd0;
            Data_out  <= 32'd0;
            byte_en   <= 4'b0000;
            MemRW     <= 1'b0;
            CPU_MIO   <= 1'b0;
          end else if (TO_EN) begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Load word register is pure data and carries no reset.
  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && MIO_ready)
      ld_word_q <= Data_in;
  end

endmodule

// File: tb/tb_mio_lsu.sv
// Directed bench for mio_lsu: loads, stores, wait states, decode errors,
// timeout boundary and asynchronous reset during a bus access.
module tb_mio_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [3:0]  byte_en;
  logic        MemRW;
  logic        CPU_MIO;
  logic [31:0] Data_in;
  logic        MIO_ready;

  int n_chk  = 0;
  int n_fail = 0;

  int          r_stall, r_acc, r_cyc;
  logic        r_done, r_err, r_mio, r_rw;
  logic [31:0] r_rdata, r_dout, r_addr;
  logic [3:0]  r_be;

  mio_lsu #(.TIMEOUT(15), .TO_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .Addr_out   (Addr_out),
    .Data_out   (Data_out),
    .byte_en    (byte_en),
    .MemRW      (MemRW),
    .CPU_MIO    (CPU_MIO),
    .Data_in    (Data_in),
    .MIO_ready  (MIO_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request from a falling edge; the bus acks on the access
  // cycle after wait_n low-ready cycles. Results land in the r_* variables.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] bus, input int wait_n);
    r_stall = 0; r_acc = 0; r_cyc = -1;
    r_done = 0; r_err = 0; r_mio = 0; r_rw = 0;
    r_rdata = 0; r_dout = 0; r_addr = 0; r_be = 0;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    MIO_ready = 0; Data_in = bus;
    for (int cyc = 0; cyc < 40 && !r_done; cyc++) begin
      #1;
      if (stall) r_stall++;
      if (CPU_MIO) begin
        r_acc++;
        r_mio = 1; r_be = byte_en; r_dout = Data_out; r_addr = Addr_out; r_rw = MemRW;
        MIO_ready = (r_acc > wait_n);
      end
      if (rsp_valid) begin
        r_done = 1; r_err = rsp_err; r_rdata = rsp_rdata; r_cyc = cyc;
        req_valid = 0; MIO_ready = 0;
      end
      @(negedge clk);
    end
    chk("rsp_seen", 32'(r_done), 32'd1);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    Data_in = 0; MIO_ready = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mio", 32'(CPU_MIO), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_be", 32'(byte_en), 32'd0);
    chk("rst_addr", Addr_out, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'd0);

    // LW, zero wait
    run_req(1'b0, 3'd2, 32'h0000_0104, 32'd0, 32'hDEADBEEF, 0);
    chk("lw_addr", r_addr, 32'h0000_0104);
    chk("lw_be", 32'(r_be), 32'hF);
    chk("lw_rw", 32'(r_rw), 32'd0);
    chk("lw_rdata", r_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(r_err), 32'd0);
    chk("lw_stall", 32'(r_stall), 32'd2);
    chk("lw_cyc", 32'(r_cyc), 32'd2);

    // LB / LBU sign vs zero extension, top byte lane
    run_req(1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h8000_0000, 0);
    chk("lb_be", 32'(r_be), 32'h8);
    chk("lb_addr", r_addr, 32'h0000_0100);
    chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
    run_req(1'b0, 3'd4, 32'h0000_0103, 32'd0, 32'h8000_0000, 0);
    chk("lbu_rdata", r_rdata, 32'h0000_0080);

    // LH / LHU, upper halfword
    run_req(1'b0, 3'd1, 32'h0000_0102, 32'd0, 32'h8001_1234, 1);
    chk("lh_rdata", r_rdata, 32'hFFFF_8001);
    chk("lh_stall", 32'(r_stall), 32'd3);
    run_req(1'b0, 3'd5, 32'h0000_0102, 32'd0, 32'h8001_1234, 0);
    chk("lhu_rdata", r_rdata, 32'h0000_8001);

    // SH with 3 wait states
    run_req(1'b1, 3'd1, 32'h0000_0202, 32'h1234ABCD, 32'hFFFF_FFFF, 3);
    chk("sh_be", 32'(r_be), 32'hC);
    chk("sh_dout", r_dout, 32'hABCDABCD);
    chk("sh_rw", 32'(r_rw), 32'd1);
    chk("sh_addr", r_addr, 32'h0000_0200);
    chk("sh_stall", 32'(r_stall), 32'd5);
    chk("sh_err", 32'(r_err), 32'd0);
    chk("sh_rdata", r_rdata, 32'd0);

    // SB replication, lane 1
    run_req(1'b1, 3'd0, 32'h0000_0301, 32'h0000_005A, 32'd0, 0);
    chk("sb_be", 32'(r_be), 32'h2);
    chk("sb_dout", r_dout, 32'h5A5A5A5A);

    // Decode errors: misaligned LW, misaligned LH, illegal store funct3
    run_req(1'b0, 3'd2, 32'h0000_0101, 32'd0, 32'd0, 0);
    chk("mis_lw_err", 32'(r_err), 32'd1);
    chk("mis_lw_cyc", 32'(r_cyc), 32'd1);
    chk("mis_lw_mio", 32'(r_mio), 32'd0);
    chk("mis_lw_rdata", r_rdata, 32'd0);
    run_req(1'b0, 3'd1, 32'h0000_0101, 32'd0, 32'd0, 0);
    chk("mis_lh_err", 32'(r_err), 32'd1);
    run_req(1'b1, 3'd3, 32'h0000_0100, 32'd0, 32'd0, 0);
    chk("ill_st_err", 32'(r_err), 32'd1);
    chk("ill_st_mio", 32'(r_mio), 32'd0);

    // Timeout: ready never rises
    run_req(1'b0, 3'd2, 32'h0000_0400, 32'd0, 32'h1111_2222, 100);
    chk("to_err", 32'(r_err), 32'd1);
    chk("to_acc", 32'(r_acc), 32'd15);
    chk("to_cyc", 32'(r_cyc), 32'd16);
    chk("to_rdata", r_rdata, 32'd0);

    // Ready on the 15th access cycle beats the timeout
    run_req(1'b0, 3'd2, 32'h0000_0400, 32'd0, 32'h1111_2222, 14);
    chk("to_edge_err", 32'(r_err), 32'd0);
    chk("to_edge_acc", 32'(r_acc), 32'd15);
    chk("to_edge_rdata", r_rdata, 32'h1111_2222);

    // Asynchronous reset while in ACCESS
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h0000_0500; MIO_ready = 0;
    @(negedge clk);
    #1;
    chk("mid_mio_pre", 32'(CPU_MIO), 32'd1);
    #1 rst = 1;
    #1;
    chk("mid_mio", 32'(CPU_MIO), 32'd0);
    chk("mid_stall", 32'(stall), 32'd0);
    chk("mid_be", 32'(byte_en), 32'd0);
    @(negedge clk);
    rst = 0; req_valid = 0;
    @(negedge clk);
    run_req(1'b0, 3'd2, 32'h0000_0508, 32'd0, 32'h0BADF00D, 1);
    chk("post_rst_rdata", r_rdata, 32'h0BADF00D);
    chk("post_rst_err", 32'(r_err), 32'd0);
    chk("post_rst_addr", r_addr, 32'h0000_0508);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
